// File: rtl/i2c_adc_sequencer.sv
// Drives a byte-level i2c master core through repeated single-shot ADS1115-style conversions.
// Optional I2C_ADC_AUTOSCAN_EN: ignore adcChannel and rotate channels 0..3 across conversions.
module i2c_adc_sequencer #(
  parameter logic [6:0]  DEV_ADDR  = 7'h48,
  parameter logic [2:0]  PGA       = 3'b001,
  parameter logic [7:0]  CFG_LSB   = 8'h83,
  parameter int unsigned CONV_WAIT = 230000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        adcEnable,
  input  logic [1:0]  adcChannel,
  output logic [15:0] adcOutputData,
  output logic [1:0]  adcChannelOut,
  output logic        adcDataReady,
  output logic [1:0]  i2cInstruction,
  output logic        i2cEnable,
  output logic [7:0]  i2cByteToSend,
  input  logic [7:0]  i2cByteReceived,
  input  logic        i2cComplete
);

  localparam int unsigned WAIT_W = (CONV_WAIT > 1) ? $clog2(CONV_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CONV_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_START = 2'b00,
    OP_STOP  = 2'b01,
    OP_READ  = 2'b10,
    OP_WRITE = 2'b11
  } i2c_op_e;

  state_e            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [1:0]        chan_q, chan_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        chan_out_q, chan_out_d;
  logic              ready_q, ready_d;

  i2c_op_e           op_ins;
  logic [7:0]        op_byte;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      chan_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      wait_q     <= '0;
      data_q     <= '0;
      chan_out_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      chan_q     <= chan_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      wait_q     <= wait_d;
      data_q     <= data_d;
      chan_out_q <= chan_out_d;
      ready_q    <= ready_d;
    end
  end

  // Per-step bus operation: config write, pointer write, two-byte read.
  always_comb begin
    op_ins  = OP_START;
    op_byte = '0;
    case (step_q)
      4'd0, 4'd6, 4'd10: op_ins = OP_START;
      4'd5, 4'd9, 4'd14: op_ins = OP_STOP;
      4'd12, 4'd13:      op_ins = OP_READ;
      4'd1, 4'd7: begin
        op_ins  = OP_WRITE;
        op_byte = {DEV_ADDR, 1'b0};
      end
      4'd2: begin
        op_ins  = OP_WRITE;
        op_byte = 8'h01;
      end
      4'd3: begin
        op_ins  = OP_WRITE;
        op_byte = {1'b1, 1'b1, chan_q, PGA, 1'b1};
      end
      4'd4: begin
        op_ins  = OP_WRITE;
        op_byte = CFG_LSB;
      end
      4'd8: begin
        op_ins  = OP_WRITE;
        op_byte = 8'h00;
      end
      4'd11: begin
        op_ins  = OP_WRITE;
        op_byte = {DEV_ADDR, 1'b1};
      end
      default: begin
        op_ins  = OP_START;
        op_byte = '0;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    chan_d         = chan_q;
    hi_d           = hi_q;
    lo_d           = lo_q;
    wait_d         = wait_q;
    data_d         = data_q;
    chan_out_d     = chan_out_q;
    ready_d        = 1'b0;
    i2cEnable      = 1'b0;
    i2cInstruction = OP_START;
    i2cByteToSend  = '0;

    case (state_q)
      S_IDLE: begin
        if (adcEnable) begin
`ifndef I2C_ADC_AUTOSCAN_EN
          chan_d = adcChannel;
`endif
          step_d  = '0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        i2cEnable      = 1'b1;
        i2cInstruction = op_ins;
        i2cByteToSend  = op_byte;
        if (i2cComplete) begin
          if (step_q == 4'd12) hi_d = i2cByteReceived;
          if (step_q == 4'd13) lo_d = i2cByteReceived;
          state_d = S_RELEASE;
        end
      end

      // The result registers load on entry to DONE so the ready pulse and data coincide.
      S_RELEASE: begin
        if (!i2cComplete) begin
          if (step_q == 4'd5) begin
            wait_d  = WAIT_LOAD;
            state_d = S_WAIT;
          end else if (step_q == 4'd14) begin
            data_d     = {hi_q, lo_q};
            chan_out_d = chan_q;
            ready_d    = 1'b1;
            state_d    = S_DONE;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end

      S_WAIT: begin
        if (wait_q == '0) begin
          step_d  = 4'd6;
          state_d = S_ISSUE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end

      S_DONE: begin
`ifdef I2C_ADC_AUTOSCAN_EN
        chan_d = chan_q + 2'd1;
`endif
        if (adcEnable) begin
`ifndef I2C_ADC_AUTOSCAN_EN
          chan_d = adcChannel;
`endif
          step_d  = '0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign adcOutputData = data_q;
  assign adcChannelOut = chan_out_q;
  assign adcDataReady  = ready_q;

endmodule

// File: doc/i2c_adc_sequencer.md
Name: i2c_adc_sequencer

Overview:
- Sequences the byte-level i2c master core (instruction/enable/complete interface) to run repeated single-shot conversions on an ADS1115-class ADC.
- Sits between the i2c core and user logic, which sees only adcEnable, adcChannel, adcOutputData and adcDataReady.
- Per conversion: writes the config register, waits for conversion time, sets the pointer to the conversion register, then reads two bytes.

Parameters:
- DEV_ADDR, 7'h48, 7-bit i2c slave address.
- PGA, 3'b001, config bits [11:9].
- CFG_LSB, 8'h83, config low byte (data rate, comparator disabled).
- CONV_WAIT, 230000, clk cycles to idle between config write and pointer write (min 1).

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous active-low reset.
- adcEnable  in  1  level; 1 = run conversions back-to-back.
- adcChannel  in  2  single-ended channel; latched at conversion start.
- adcOutputData  out  16  last result {hi,lo}.
- adcChannelOut  out  2  channel of adcOutputData.
- adcDataReady  out  1  one-cycle pulse when adcOutputData updates.
- i2cInstruction  out  2  00 START, 01 STOP, 10 READ, 11 WRITE.
- i2cEnable  out  1  request to core.
- i2cByteToSend  out  8  byte for WRITE.
- i2cByteReceived  in  8  byte from READ, valid while i2cComplete=1.
- i2cComplete  in  1  core op finished.

Behaviour:
- Reset (resetN=0 at rising clk edge): state IDLE, step=0, i2cEnable=0, i2cInstruction=00, i2cByteToSend=0, adcOutputData=0, adcChannelOut=0, adcDataReady=0, wait counter=0.
- Reset mid-transaction aborts immediately. i2cEnable is 0 from the next edge. No STOP is issued; bus recovery is the core's concern.
- States: IDLE, ISSUE, RELEASE, WAIT, DONE.
- IDLE: if adcEnable=1, latch adcChannel into chanReg, set step=0, go ISSUE.
- ISSUE: drive step's instruction and byte with i2cEnable=1. Hold all three stable until i2cComplete=1 is sampled.
  - On that edge: if the step is READ, capture i2cByteReceived into hi (step 12) or lo (step 13).
  - Then go RELEASE with i2cEnable=0.
- RELEASE: hold i2cEnable=0 until i2cComplete=0 is sampled (minimum 1 cycle). Then advance:
  - step 5 -> WAIT (counter loaded with CONV_WAIT-1);
  - step 14 -> DONE;
  - otherwise step+1 -> ISSUE.
- WAIT: decrement the counter each cycle. At 0, set step=6 and go ISSUE. Total WAIT dwell = CONV_WAIT cycles.
- Step table:
  - 0 START
  - 1 WRITE {DEV_ADDR,0}
  - 2 WRITE 8'h01
  - 3 WRITE {1'b1,1'b1,chanReg,PGA,1'b1}
  - 4 WRITE CFG_LSB
  - 5 STOP
  - 6 START
  - 7 WRITE {DEV_ADDR,0}
  - 8 WRITE 8'h00
  - 9 STOP
  - 10 START
  - 11 WRITE {DEV_ADDR,1}
  - 12 READ
  - 13 READ
  - 14 STOP
  - i2cByteToSend is don't-care for START, STOP and READ; drive 0.
- DONE (one cycle): adcOutputData <= {hi,lo}, adcChannelOut <= chanReg, adcDataReady=1 for exactly this cycle.
  - Next: if adcEnable=1, latch the channel and go ISSUE at step 0; else go IDLE.
- adcEnable falling mid-conversion: the current conversion completes through step 14 and DONE, including the result pulse, then the block idles. The bus is never left without STOP.
- adcChannel changes mid-conversion: ignored until the next latch.
- i2cComplete high in IDLE or WAIT: ignored.
- i2cComplete already high on entry to ISSUE is a core protocol violation. Not required to be handled beyond RELEASE waiting for it to fall.
- Latency per conversion = 15 core ops + 15 RELEASE gaps + CONV_WAIT + 1 DONE cycle.

Optional Feature:
- Macro: I2C_ADC_AUTOSCAN_EN.
- Defined: adcChannel input is ignored. chanReg starts at 0 after reset and increments by 1 at each DONE, wrapping 3 -> 0. adcChannelOut tags each result.
- Undefined: chanReg is latched from adcChannel as described above, and adcChannelOut echoes it.

Test Plan:
- Basic conversion. Stimulus: CONV_WAIT=4, adcChannel=2, adcEnable pulsed high for 1 cycle; core model completes each op 3 cycles after enable and returns 8'h12 then 8'h34. Required: exact 15-op instruction/byte sequence with step 3 byte = 8'hE3 and step 11 byte = 8'h91; after step 14, one adcDataReady pulse with adcOutputData=16'h1234 and adcChannelOut=2.
- Handshake. Stimulus: core holds i2cComplete high for 5 cycles. Required: i2cEnable low throughout, no next op until complete falls, no double READ capture.
- Wait timing. Stimulus: CONV_WAIT=10. Required: exactly 10 cycles between RELEASE of step 5 and i2cEnable for step 6.
- Enable drop mid-run. Stimulus: adcEnable=1 continuously, deasserted at step 7. Required: steps 8-14 still issued, one ready pulse, then IDLE with i2cEnable=0.
- Reset mid-op. Stimulus: resetN=0 during ISSUE at step 12 for 1 cycle. Required: next edge i2cEnable=0, all outputs at reset values, no ready pulse; restart from step 0 when adcEnable=1.
- Autoscan (I2C_ADC_AUTOSCAN_EN defined). Stimulus: adcEnable=1 for 5 conversions. Required: step 3 bytes E3-equivalent for channels 0,1,2,3,0, i.e. 8'hC3, 8'hD3, 8'hE3, 8'hF3, 8'hC3; adcChannelOut 0,1,2,3,0.
